// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential 16/8 restoring divider.
// DIV_RADIX4_EN selects two restoring steps per cycle instead of one.
package div_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } div_state_e;

    localparam int unsigned DIV_DW = 16;
    localparam int unsigned DIV_VW = 8;
    // One extra bit: the shifted partial remainder can reach 2*255.
    localparam int unsigned DIV_RW = DIV_VW + 1;

`ifdef DIV_RADIX4_EN
    localparam int unsigned DIV_STEPS_PER_CYC = 2;
`else
    localparam int unsigned DIV_STEPS_PER_CYC = 1;
`endif

    localparam int unsigned DIV_ITERS = DIV_DW / DIV_STEPS_PER_CYC;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// subtract the divisor when it fits and report the resulting quotient bit.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned VW = DIV_VW
) (
    input  logic [VW:0]   r_i,
    input  logic          bit_i,
    input  logic [VW-1:0] divisor_i,
    output logic [VW:0]   r_o,
    output logic          q_o
);

    logic [VW:0] r_sh;
    // The incoming remainder is always below the divisor, so its MSB is zero.
    logic        unused_r_msb;

    assign r_sh         = {r_i[VW-1:0], bit_i};
    assign unused_r_msb = r_i[VW];

    always_comb begin
        q_o = (r_sh >= {1'b0, divisor_i});
        r_o = q_o ? (r_sh - {1'b0, divisor_i}) : r_sh;
    end

endmodule

// File: rtl/seq_div_16by8.sv
// Sequential restoring divider with valid/ready on both sides.
// Build with DIV_RADIX4_EN defined to retire two quotient bits per cycle.
module seq_div_16by8
    import div_pkg::*;
#(
    parameter int unsigned DW = DIV_DW,
    parameter int unsigned VW = DIV_VW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int unsigned Iters = DW / DIV_STEPS_PER_CYC;
    localparam int unsigned CW    = (Iters > 1) ? $clog2(Iters) : 1;

    div_state_e    state_q, state_d;
    logic [DW-1:0] q_q, q_d;
    logic [VW:0]   r_q, r_d;
    logic [VW-1:0] d_q, d_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dbz_q, dbz_d;

    logic [DW-1:0] q_step;
    logic [VW:0]   r_step;
    logic          qb0;
    logic [VW:0]   r_s0;

    div_step #(.VW(VW)) u_step0 (
        .r_i       (r_q),
        .bit_i     (q_q[DW-1]),
        .divisor_i (d_q),
        .r_o       (r_s0),
        .q_o       (qb0)
    );

`ifdef DIV_RADIX4_EN
    logic qb1;

    div_step #(.VW(VW)) u_step1 (
        .r_i       (r_s0),
        .bit_i     (q_q[DW-2]),
        .divisor_i (d_q),
        .r_o       (r_step),
        .q_o       (qb1)
    );

    assign q_step = {q_q[DW-3:0], qb0, qb1};
`else
    assign r_step = r_s0;
    assign q_step = {q_q[DW-2:0], qb0};
`endif

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (divisor == '0) begin
                        q_d     = '1;
                        r_d     = {1'b0, dividend[VW-1:0]};
                        dbz_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        q_d     = dividend;
                        r_d     = '0;
                        d_d     = divisor;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                q_d   = q_step;
                r_d   = r_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(Iters - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready    = (state_q == StIdle);
    assign out_valid   = (state_q == StDone);
    assign quotient    = q_q;
    assign remainder   = r_q[VW-1:0];
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div_16by8.sv
// Self-checking bench for seq_div_16by8: arithmetic reference model plus
// directed operations with hand-computed results and latencies.
module tb_seq_div_16by8;

`ifdef DIV_RADIX4_EN
    localparam int LAT = 8;
`else
    localparam int LAT = 16;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int total = 0;
    int bad   = 0;

    seq_div_16by8 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model: tracks only "busy for N cycles" / "result waiting"
    logic        m_busy;
    logic        m_valid;
    int          m_cnt;
    logic [15:0] m_q;
    logic [7:0]  m_r;
    logic        m_dbz;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_cnt   <= 0;
        end else if (m_valid) begin
            if (out_ready) m_valid <= 1'b0;
        end else if (m_busy) begin
            if (m_cnt == 1) begin
                m_busy  <= 1'b0;
                m_valid <= 1'b1;
            end
            m_cnt <= m_cnt - 1;
        end else if (in_valid) begin
            if (divisor == 8'd0) begin
                m_q     <= 16'hFFFF;
                m_r     <= dividend[7:0];
                m_dbz   <= 1'b1;
                m_valid <= 1'b1;
            end else begin
                m_q    <= dividend / {8'd0, divisor};
                m_r    <= 8'(dividend % {8'd0, divisor});
                m_dbz  <= 1'b0;
                m_busy <= 1'b1;
                m_cnt  <= LAT;
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", 32'(in_ready), 32'(!(m_busy || m_valid)));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            chk("quotient", 32'(quotient), 32'(m_q));
            chk("remainder", 32'(remainder), 32'(m_r));
            chk("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
        end
    end

    // Issue one operation; hold: cycles to keep out_ready low once valid;
    // toggle: wiggle in_valid/operands while the divider is busy.
    task automatic do_op(input logic [15:0] a, input logic [7:0] b,
                         input logic [15:0] eq, input logic [7:0] er, input logic edz,
                         input int elat, input int hold, input bit toggle);
        int n;
        @(negedge clk);
        in_valid  = 1'b1;
        dividend  = a;
        divisor   = b;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            if (toggle) begin
                in_valid = n[0];
                dividend = 16'(n * 977);
                divisor  = 8'(n + 3);
            end
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        chk("latency", 32'(n), 32'(elat));
        chk("lit_quotient", 32'(quotient), 32'(eq));
        chk("lit_remainder", 32'(remainder), 32'(er));
        chk("lit_dbz", 32'(div_by_zero), 32'(edz));
        chk("model_q_pin", 32'(m_q), 32'(eq));
        chk("model_r_pin", 32'(m_r), 32'(er));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_quotient", 32'(quotient), 32'(eq));
            chk("bp_remainder", 32'(remainder), 32'(er));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("consumed_valid", 32'(out_valid), 32'd0);
        chk("consumed_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;

        do_op(16'd28702, 8'd254, 16'd113, 8'd0, 1'b0, LAT, 0, 1'b0);
        do_op(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, LAT, 0, 1'b0);
        do_op(16'd65535, 8'd1, 16'd65535, 8'd0, 1'b0, LAT, 0, 1'b0);
        do_op(16'd43648, 8'd248, 16'd176, 8'd0, 1'b0, LAT, 0, 1'b0);
        do_op(16'd513, 8'd0, 16'hFFFF, 8'd1, 1'b1, 0, 0, 1'b0);
        do_op(16'd50, 8'd5, 16'd10, 8'd0, 1'b0, LAT, 0, 1'b0);
        do_op(16'd300, 8'd255, 16'd1, 8'd45, 1'b0, LAT, 10, 1'b0);
        do_op(16'd40000, 8'd123, 16'd325, 8'd25, 1'b0, LAT, 0, 1'b1);

        // Abort 60000/3 five cycles after acceptance
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 16'd60000;
        divisor  = 8'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre_abort_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 4) begin
            @(posedge clk);
            #1;
            chk("no_stale_valid", 32'(out_valid), 32'd0);
        end
        do_op(16'd9, 8'd2, 16'd4, 8'd1, 1'b0, LAT, 0, 1'b0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
